// File: rtl/reg_file_param_if.sv
// Register-file access bus: one write port, two enabled read ports, plus
// clear-sequence status returned by the file.
interface reg_file_param_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
);
  logic              reg_write;
  logic [ADDR_W-1:0] rd;
  logic [DATA_W-1:0] write_data;
  logic              re1;
  logic [ADDR_W-1:0] rs1;
  logic              re2;
  logic [ADDR_W-1:0] rs2;
  logic [DATA_W-1:0] out1;
  logic [DATA_W-1:0] out2;
  logic              busy;
  logic              wr_drop;

  modport master (
    output reg_write, rd, write_data, re1, rs1, re2, rs2,
    input  out1, out2, busy, wr_drop
  );

  modport slave (
    input  reg_write, rd, write_data, re1, rs1, re2, rs2,
    output out1, out2, busy, wr_drop
  );
endinterface

// File: rtl/reg_file_param.sv
// Parametrised 1W/2R register file with registered reads, write-first bypass,
// optional hardwired-zero entry 0 and a post-reset clear sequencer.
module reg_file_param #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int          ZERO_REG = 1
) (
  input  logic          clk,
  input  logic          rst,
  reg_file_param_if.slave bus
);

  localparam int unsigned DEPTH = 2**ADDR_W;
  localparam bit          ZR    = (ZERO_REG != 0);

  typedef enum logic {S_CLEAR, S_READY} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] out1_q, out1_d;
  logic [DATA_W-1:0] out2_q, out2_d;
  logic              busy_q, busy_d;
  logic              wr_drop_q, wr_drop_d;

  logic [DATA_W-1:0] mem [DEPTH];
  logic              mem_we_c;
  logic [ADDR_W-1:0] mem_waddr_c;
  logic [DATA_W-1:0] mem_wdata_c;
  logic              wr_ok_c;
  logic [DATA_W-1:0] mem_rd1_c, mem_rd2_c;

  assign mem_rd1_c = mem[bus.rs1];
  assign mem_rd2_c = mem[bus.rs2];

  // Read-port resolution: zero entry first, then same-cycle bypass, then storage.
  function automatic logic [DATA_W-1:0] resolve_read(
    input logic              re,
    input logic [ADDR_W-1:0] rs,
    input logic [DATA_W-1:0] stored,
    input logic [DATA_W-1:0] held,
    input logic              wr_ok,
    input logic [ADDR_W-1:0] wa,
    input logic [DATA_W-1:0] wd
  );
    logic [DATA_W-1:0] val;
    val = held;
    if (re) begin
      if (ZR && (rs == '0))          val = '0;
      else if (wr_ok && (wa == rs))  val = wd;
      else                           val = stored;
    end
    return val;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_CLEAR;
      cnt_q     <= '0;
      out1_q    <= '0;
      out2_q    <= '0;
      busy_q    <= 1'b1;
      wr_drop_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      out1_q    <= out1_d;
      out2_q    <= out2_d;
      busy_q    <= busy_d;
      wr_drop_q <= wr_drop_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    out1_d      = out1_q;
    out2_d      = out2_q;
    busy_d      = busy_q;
    wr_drop_d   = 1'b0;
    mem_we_c    = 1'b0;
    mem_waddr_c = cnt_q;
    mem_wdata_c = '0;
    wr_ok_c     = 1'b0;

    unique case (state_q)
      S_CLEAR: begin
        mem_we_c  = 1'b1;
        cnt_d     = cnt_q + ADDR_W'(1);
        wr_drop_d = bus.reg_write;
        busy_d    = 1'b1;
        if (bus.re1) out1_d = '0;
        if (bus.re2) out2_d = '0;
        if (cnt_q == ADDR_W'(DEPTH - 1)) begin
          state_d = S_READY;
          busy_d  = 1'b0;
        end
      end
      S_READY: begin
        wr_ok_c     = bus.reg_write && !(ZR && (bus.rd == '0));
        mem_we_c    = wr_ok_c;
        mem_waddr_c = bus.rd;
        mem_wdata_c = bus.write_data;
        busy_d      = 1'b0;
        out1_d = resolve_read(bus.re1, bus.rs1, mem_rd1_c, out1_q,
                              wr_ok_c, bus.rd, bus.write_data);
        out2_d = resolve_read(bus.re2, bus.rs2, mem_rd2_c, out2_q,
                              wr_ok_c, bus.rd, bus.write_data);
      end
    endcase
  end

  // Storage is not reset directly; the clear sequence zeroes it after rst drops.
  always_ff @(posedge clk) begin
    if (mem_we_c && !rst) mem[mem_waddr_c] <= mem_wdata_c;
  end

  assign bus.out1    = out1_q;
  assign bus.out2    = out2_q;
  assign bus.busy    = busy_q;
  assign bus.wr_drop = wr_drop_q;

endmodule

// File: tb/tb_reg_file_param.sv
// Bench for reg_file_param: two instances (ZERO_REG=1 and ZERO_REG=0) driven
// identically and compared every cycle against an array-based reference model.
module tb_reg_file_param;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DEPTH  = 2**ADDR_W;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  reg_file_param_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus_z ();
  reg_file_param_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus_n ();

  reg_file_param #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(1)) dut_z (
    .clk(clk), .rst(rst), .bus(bus_z)
  );
  reg_file_param #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(0)) dut_n (
    .clk(clk), .rst(rst), .bus(bus_n)
  );

  int checks = 0;
  int errors = 0;

  // Reference state; index 0 models ZERO_REG=1, index 1 models ZERO_REG=0.
  logic [DATA_W-1:0] m_mem [2][DEPTH];
  logic [DATA_W-1:0] m_out1 [2];
  logic [DATA_W-1:0] m_out2 [2];
  logic              m_busy [2];
  logic              m_drop [2];
  int                m_clear_left [2];

  task automatic check(input string tag, input logic [DATA_W-1:0] obs,
                       input logic [DATA_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [DATA_W-1:0] model_read(input int v, input logic re,
      input int rs, input logic wr, input int wa, input logic [DATA_W-1:0] wd,
      input logic [DATA_W-1:0] held);
    bit zr;
    zr = (v == 0);
    if (!re) return held;
    if (zr && rs == 0) return '0;
    if (wr && wa == rs && !(zr && wa == 0)) return wd;
    return m_mem[v][rs];
  endfunction

  task automatic model_edge(input logic r, input logic wr, input int wa,
      input logic [DATA_W-1:0] wd, input logic r1, input int a1,
      input logic r2, input int a2);
    for (int v = 0; v < 2; v++) begin
      if (r) begin
        m_clear_left[v] = DEPTH;
        m_out1[v] = '0; m_out2[v] = '0; m_busy[v] = 1'b1; m_drop[v] = 1'b0;
      end else if (m_clear_left[v] > 0) begin
        m_mem[v][DEPTH - m_clear_left[v]] = '0;
        m_clear_left[v]--;
        m_drop[v] = wr;
        if (r1) m_out1[v] = '0;
        if (r2) m_out2[v] = '0;
        m_busy[v] = (m_clear_left[v] > 0);
      end else begin
        m_out1[v] = model_read(v, r1, a1, wr, wa, wd, m_out1[v]);
        m_out2[v] = model_read(v, r2, a2, wr, wa, wd, m_out2[v]);
        if (wr && !(v == 0 && wa == 0)) m_mem[v][wa] = wd;
        m_drop[v] = 1'b0;
        m_busy[v] = 1'b0;
      end
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, "/z.out1"},    bus_z.out1,               m_out1[0]);
    check({tag, "/z.out2"},    bus_z.out2,               m_out2[0]);
    check({tag, "/z.busy"},    DATA_W'(bus_z.busy),     DATA_W'(m_busy[0]));
    check({tag, "/z.wr_drop"}, DATA_W'(bus_z.wr_drop),  DATA_W'(m_drop[0]));
    check({tag, "/n.out1"},    bus_n.out1,               m_out1[1]);
    check({tag, "/n.out2"},    bus_n.out2,               m_out2[1]);
    check({tag, "/n.busy"},    DATA_W'(bus_n.busy),     DATA_W'(m_busy[1]));
    check({tag, "/n.wr_drop"}, DATA_W'(bus_n.wr_drop),  DATA_W'(m_drop[1]));
  endtask

  // One clock: drive inputs, take the edge, advance the model, check #1 later.
  task automatic step(input string tag, input logic r, input logic wr,
      input int wa, input logic [DATA_W-1:0] wd, input logic r1, input int a1,
      input logic r2, input int a2);
    rst = r;
    bus_z.reg_write = wr;         bus_n.reg_write = wr;
    bus_z.rd = ADDR_W'(wa);       bus_n.rd = ADDR_W'(wa);
    bus_z.write_data = wd;        bus_n.write_data = wd;
    bus_z.re1 = r1;               bus_n.re1 = r1;
    bus_z.rs1 = ADDR_W'(a1);      bus_n.rs1 = ADDR_W'(a1);
    bus_z.re2 = r2;               bus_n.re2 = r2;
    bus_z.rs2 = ADDR_W'(a2);      bus_n.rs2 = ADDR_W'(a2);
    @(posedge clk);
    model_edge(r, wr, wa, wd, r1, a1, r2, a2);
    #1;
    check_all(tag);
  endtask

  task automatic idle(input string tag);
    step(tag, 1'b0, 1'b0, 0, '0, 1'b0, 0, 1'b0, 0);
  endtask

  initial begin
    for (int v = 0; v < 2; v++) begin
      m_clear_left[v] = DEPTH;
      for (int i = 0; i < int'(DEPTH); i++) m_mem[v][i] = 'x;
    end

    // Reset held two cycles, then a full clear with idle inputs.
    step("reset0", 1'b1, 1'b0, 0, '0, 1'b0, 0, 1'b0, 0);
    step("reset1", 1'b1, 1'b0, 0, '0, 1'b0, 0, 1'b0, 0);
    check("reset.busy_const", DATA_W'(bus_z.busy), DATA_W'(1));
    for (int i = 0; i < int'(DEPTH); i++) idle("clear");
    check("clear_done.busy", DATA_W'(bus_z.busy), DATA_W'(0));

    // Every entry reads zero after clear.
    for (int i = 0; i < int'(DEPTH); i++)
      step("read_zero", 1'b0, 1'b0, 0, '0, 1'b1, i, 1'b1, DEPTH - 1 - i);

    // Basic write then read.
    step("wr5", 1'b0, 1'b1, 5, 32'hDEADBEEF, 1'b0, 0, 1'b0, 0);
    step("rd5", 1'b0, 1'b0, 0, '0, 1'b1, 5, 1'b1, 6);
    check("rd5.literal", bus_z.out1, 32'hDEADBEEF);

    // Bypass on both ports, then a later plain read.
    step("byp7", 1'b0, 1'b1, 7, 32'h12345678, 1'b1, 7, 1'b1, 7);
    check("byp7.literal", bus_z.out2, 32'h12345678);
    idle("gap");
    step("rd7", 1'b0, 1'b0, 0, '0, 1'b1, 7, 1'b0, 0);

    // Zero register: write with bypass to entry 0, then read it back.
    step("zr_wr", 1'b0, 1'b1, 0, 32'hFFFFFFFF, 1'b1, 0, 1'b0, 0);
    check("zr_wr.z_out1", bus_z.out1, 32'h0);
    check("zr_wr.n_out1", bus_n.out1, 32'hFFFFFFFF);
    step("zr_rd", 1'b0, 1'b0, 0, '0, 1'b1, 0, 1'b1, 0);

    // Hold: out1 keeps its value while the entry it last read is rewritten.
    step("hold_wr", 1'b0, 1'b1, 9, 32'h0BADF00D, 1'b0, 0, 1'b0, 0);
    step("hold_rd", 1'b0, 1'b0, 0, '0, 1'b1, 9, 1'b0, 0);
    step("hold_rw", 1'b0, 1'b1, 9, 32'hCAFEBABE, 1'b0, 9, 1'b0, 9);
    check("hold.literal", bus_z.out1, 32'h0BADF00D);
    step("hold_chk", 1'b0, 1'b0, 0, '0, 1'b0, 9, 1'b1, 9);

    // Random traffic with small-address bias to provoke collisions.
    for (int n = 0; n < 400; n++) begin
      int unsigned span;
      span = ($urandom_range(0, 3) == 0) ? DEPTH - 1 : 7;
      step("rand", 1'b0, 1'($urandom_range(0, 1)), int'($urandom_range(0, span)),
           DATA_W'($urandom), 1'($urandom_range(0, 1)), int'($urandom_range(0, span)),
           1'($urandom_range(0, 1)), int'($urandom_range(0, span)));
    end

    // Second clear: write dropped on cycle 10, read during clear, restart at 20.
    step("rst2", 1'b1, 1'b0, 0, '0, 1'b0, 0, 1'b0, 0);
    for (int c = 0; c < 20; c++) begin
      if (c == 10)
        step("clr_wr", 1'b0, 1'b1, 3, 32'hAAAA5555, 1'b1, 3, 1'b0, 0);
      else
        idle("clr_a");
    end
    step("rst_mid", 1'b1, 1'b0, 0, '0, 1'b0, 0, 1'b0, 0);
    for (int c = 0; c < int'(DEPTH) - 1; c++) idle("clr_b");
    check("restart.busy_high", DATA_W'(bus_z.busy), DATA_W'(1));
    idle("clr_end");
    check("restart.busy_low", DATA_W'(bus_z.busy), DATA_W'(0));
    step("rd3", 1'b0, 1'b0, 0, '0, 1'b1, 3, 1'b1, 3);

    for (int n = 0; n < 200; n++) begin
      step("rand2", 1'b0, 1'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
           DATA_W'($urandom), 1'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
           1'($urandom_range(0, 1)), int'($urandom_range(0, 7)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_file_param.md
# reg_file_param

Parametrised synchronous register file for the RISC-V datapath: one write port and two independently enabled read ports, with registered (1-cycle) reads. Reads and writes may happen in the same cycle, and write-first bypass resolves same-address collisions. After reset, a clear sequencer zeroes every entry before the file accepts traffic. It sits between decode (rs1/rs2/rd) and execute/writeback, replacing the fixed 32x32 read-or-write file.

## Interface
- `DATA_W`, default 32: width of each register and data port.
- `ADDR_W`, default 5: address width. Depth `DEPTH = 2**ADDR_W`.
- `ZERO_REG`, default 1: 1 = entry 0 is hardwired to zero; 0 = entry 0 is an ordinary register.
- `clk`, in, 1: system clock. All logic is on the rising edge.
- `rst`, in, 1: reset, synchronous and active-high.
- `reg_write`, in, 1: write enable.
- `rd`, in, `ADDR_W`: write address.
- `write_data`, in, `DATA_W`: write data.
- `re1`, in, 1: read enable, port 1.
- `rs1`, in, `ADDR_W`: read address, port 1.
- `re2`, in, 1: read enable, port 2.
- `rs2`, in, `ADDR_W`: read address, port 2.
- `out1`, out, `DATA_W`: registered read data, port 1.
- `out2`, out, `DATA_W`: registered read data, port 2.
- `busy`, out, 1: high while the clear sequence runs.
- `wr_drop`, out, 1: 1-cycle pulse when a write is discarded during clear.

## Operation
- States:
  - `CLEAR`: zero the storage, one entry per cycle.
  - `READY`: normal operation.
- Reset, on the rising edge with `rst=1`:
  - state becomes `CLEAR` and the clear counter becomes 0;
  - `out1=0`, `out2=0`, `busy=1`, `wr_drop=0`.
  - `rst` has priority over everything, including a clear already in progress, which restarts from entry 0.
- `CLEAR`, each cycle:
  - `mem[cnt] <= 0`, then `cnt <= cnt + 1`.
  - On the cycle that writes `cnt == DEPTH-1`, the next state is `READY` and `busy` falls on that same edge.
  - `cnt` is `ADDR_W` bits wide and wraps to 0; wrap-around never occurs without the transition to `READY`.
- `CLEAR` traffic handling:
  - `reg_write=1` is ignored. `wr_drop` is 1 for the following cycle.
  - A read with `reNx=1` loads 0 into `outN`.
  - A read with `reNx=0` holds `outN`.
- `READY`, write: when `reg_write=1`, `mem[rd] <= write_data`. When `ZERO_REG=1` and `rd==0`, the write is silently discarded; `wr_drop` does not pulse.
- `READY`, read on port N with `reN=1`, priority order:
  1. `ZERO_REG=1` and `rsN==0`: `outN <= 0`.
  2. `reg_write=1` and `rd==rsN` (write to entry 0 with `ZERO_REG=1` excluded): `outN <= write_data` (bypass).
  3. Otherwise: `outN <= mem[rsN]`.
- `READY`, port N with `reN=0`: `outN` holds its value.
- Both ports may address the same entry; each port resolves independently.
- Storage contents change only by writes and by clear. Deasserting `rst` does not start a second clear.

## Timing
- Read latency is 1 cycle: `outN` reflects the address and enable sampled at edge k and is valid after edge k.
- A write at edge k is visible to a non-bypassed read sampled at edge k+1. A bypassed read at edge k already returns the new data.
- The clear sequence lasts exactly `DEPTH` cycles after the reset edge:
  - the first edge with `rst=0` writes entry 0;
  - `busy` is low after edge `DEPTH` counted from the release of `rst`.
- `wr_drop` is registered and is asserted for exactly one cycle per dropped write.
- Output values at reset: `out1=0`, `out2=0`, `busy=1`, `wr_drop=0`.

## Test plan
- **Reset clear:** hold `rst` 2 cycles then release, with defaults.
  - `busy` stays high for 32 cycles, then goes low.
  - Reads of every address then return `0x00000000`.
- **Basic write/read:**
  - Write `0xDEADBEEF` to entry 5. The next cycle, `re1=1, rs1=5` gives `out1=0xDEADBEEF` one cycle later.
  - In the same cycle, `re2=1, rs2=6` gives `out2=0`.
- **Bypass:** in one cycle, `reg_write=1`, `rd=7`, `write_data=0x12345678`, `re1=re2=1`, `rs1=rs2=7`.
  - Both outputs read `0x12345678` after that edge.
  - Entry 7 holds the value on a later read.
- **Zero register:**
  - Write `0xFFFFFFFF` to entry 0 with bypass active on `rs1=0`. `out1=0`, a later read of entry 0 returns 0, and `wr_drop` stays 0.
  - Repeat with `ZERO_REG=0`: `out1=0xFFFFFFFF`.
- **Write during clear:**
  - Assert `reg_write` with `rd=3`, `0xAAAA5555` on clear cycle 10. `wr_drop=1` for one cycle. After `busy` falls, entry 3 reads 0.
  - A read with `re1=1` issued during clear returns 0.
- **Mid-clear reset and hold:**
  - Re-assert `rst` at clear cycle 20. `busy` then stays high for a full 32 further cycles.
  - In `READY`, with `re1=0`, `out1` holds its last value while the addressed entry is rewritten.
